bidir_deserializer: RTL and testbench
=====================================

Name: bidir_deserializer

Overview:
Receive-side counterpart of the team's bidirectional shift register. Collects a serial bit stream, MSB-first or LSB-first selected per frame, into n-bit words. Each completed word sits in a single-entry holding register and is handed off with a valid/ready handshake. Flags an overrun when a word completes while the holding register is still occupied.

Parameters:
n, 6, word width in bits (n >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; synchronous, active-high
mode  input  1  1 = LSB-first (right-shift, new bit enters at MSB); 0 = MSB-first (left-shift, new bit enters at LSB); sampled at frame start only
serial_in  input  1  serial data bit
in_en  input  1  serial_in is valid this cycle; one bit consumed per asserted cycle
sync  input  1  frame restart: discard partial frame, begin new frame
q  output  n  holding-register word, stable while data_valid=1
data_valid  output  1  q holds an unconsumed word
data_ready  input  1  consumer accepts q when data_valid && data_ready
overrun  output  1  sticky: a completed word was dropped
bit_cnt  output  clog2(n)  bits received in current frame, 0..n-1

Behaviour:
- Reset (rst=1 at clk edge): q=0, data_valid=0, overrun=0, bit_cnt=0, shift register=0, latched mode=0. rst overrides every other input, including mid-frame; the partial frame is lost.
- Mode latch: when in_en=1 and the effective count is 0, mode is latched and used for the whole frame. Mode changes mid-frame have no effect until the next frame.
- Shift, mode latched 1: sreg <= {serial_in, sreg[n-1:1]}.
- Shift, mode latched 0: sreg <= {sreg[n-2:0], serial_in}.
- Counter: each in_en increments bit_cnt. On the n-th bit (bit_cnt==n-1 with in_en=1), bit_cnt wraps to 0 and the word completes. The completed word is the shifted value including the current bit.
- Completion: the word moves to q when data_valid=0, or when data_valid=1 and data_ready=1 in the same cycle. In both cases data_valid=1 the next cycle. Latency is 1 clk from the edge sampling the last bit to q/data_valid.
- Overrun: if completion occurs while data_valid=1 and data_ready=0, the new word is dropped, q is unchanged and overrun is set to 1. overrun clears only on rst.
- Handshake: data_valid stays high, with q stable, until a cycle with data_ready=1. With no completion in that cycle, data_valid=0 next cycle. data_ready while data_valid=0 is ignored.
- sync:
  - sync=1, in_en=0: bit_cnt<=0 and sreg<=0; q, data_valid and overrun are unaffected.
  - sync=1, in_en=1: the partial frame is discarded and serial_in becomes bit 1 of a new frame. Mode is re-latched, bit_cnt<=1 and sreg holds only the new bit.
- in_en=0 and sync=0: sreg and bit_cnt hold.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- LSB-first word: rst, then mode=1, bits 1,0,1,1,0,0 with in_en=1 on 6 consecutive cycles -> 1 clk after the 6th bit, q=6'b001101 (0x0D), data_valid=1, bit_cnt=0.
- MSB-first word: mode=0, same bit sequence -> q=6'b101100 (0x2C). Then data_ready=1 for 1 cycle -> data_valid=0 next cycle, q holds 0x2C.
- Mode change mid-frame: mode=1 for bits 1,0,1, then mode=0 for bits 1,0,0 -> q=0x0D, since mode was latched at frame start.
- Overrun and back-to-back acceptance:
  - data_ready=0; send word A=0x0D, then word B=0x2C -> q stays 0x0D, overrun=1, data_valid=1.
  - Then data_ready=1 held and word C sent -> C accepted; overrun remains 1 until rst.
- Simultaneous complete and accept: data_valid=1 (q=0x0D) and data_ready=1 on the same edge that samples the 6th bit of 0x2C -> next cycle q=0x2C, data_valid=1, overrun=0.
- sync and reset mid-frame:
  - After 3 bits, sync=1 with in_en=0 -> bit_cnt=0. The next 6 bits form a clean word.
  - After 4 bits, sync=1 with in_en=1 -> bit_cnt=1.
  - rst=1 mid-frame with data_valid=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bidir_deserializer.sv
// Serial-to-parallel receiver. Bits arrive MSB-first or LSB-first (chosen at
// the start of each frame), are gathered into n-bit words, and each finished
// word is offered from a single-entry holding register with valid/ready.
//
// Handshake: q is a transfer when data_valid && data_ready on a rising edge.
// While data_valid is high, q is held stable until that transfer happens.
// data_ready with data_valid low has no effect. A word that completes while
// the holding register is full and not being drained is dropped, and the
// sticky overrun flag is raised.
module bidir_deserializer #(
    parameter int n = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 serial_in,
    input  logic                 in_en,
    input  logic                 sync,
    output logic [n-1:0]         q,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 overrun,
    output logic [$clog2(n)-1:0] bit_cnt
);

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] LAST_BIT = CW'(n - 1);

    logic [n-1:0]  sreg;
    logic          mode_q;

    logic [CW-1:0] eff_cnt;
    logic          frame_start;
    logic          shift_mode;
    logic [n-1:0]  base;
    logic [n-1:0]  shifted;
    logic          word_done;

    // A sync restarts the frame in the same cycle, so the count and shift
    // register the incoming bit builds on are zeroed before shifting.
    always_comb begin
        eff_cnt     = sync ? '0 : bit_cnt;
        frame_start = (eff_cnt == '0);
        shift_mode  = frame_start ? mode : mode_q;
        base        = sync ? '0 : sreg;
        if (shift_mode) begin
            shifted = {serial_in, base[n-1:1]};
        end else begin
            shifted = {base[n-2:0], serial_in};
        end
        word_done   = in_en && (eff_cnt == LAST_BIT);
    end

    // Frame assembly: shift register, bit counter and per-frame mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            mode_q  <= 1'b0;
        end else if (in_en) begin
            sreg    <= shifted;
            bit_cnt <= word_done ? '0 : eff_cnt + 1'b1;
            if (frame_start) begin
                mode_q <= mode;
            end
        end else if (sync) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end
    end

    // Holding register: load on completion if empty or being drained,
    // otherwise drop the word and record the overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (word_done) begin
            if (!data_valid || data_ready) begin
                q          <= shifted;
                data_valid <= 1'b1;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bidir_deserializer.sv
// Directed bench for bidir_deserializer with hand-computed expected words.
module tb_bidir_deserializer;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       serial_in;
    logic       in_en;
    logic       sync;
    logic [5:0] q;
    logic       data_valid;
    logic       data_ready;
    logic       overrun;
    logic [2:0] bit_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    bidir_deserializer #(.n(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .serial_in  (serial_in),
        .in_en      (in_en),
        .sync       (sync),
        .q          (q),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .bit_cnt    (bit_cnt)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge and sample just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic m, input logic b);
        mode      = m;
        serial_in = b;
        in_en     = 1'b1;
        tick();
        in_en     = 1'b0;
    endtask

    // seq[5] is sent first
    task automatic send_word(input logic m, input logic [5:0] seq);
        for (int i = 5; i >= 0; i--) begin
            send_bit(m, seq[i]);
        end
    endtask

    task automatic accept();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (q !== 6'h00) $display("FAIL reset_q actual=%h required=%h", q, 6'h00); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_valid actual=%b required=0", data_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun actual=%b required=0", overrun); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 3'd0) $display("FAIL reset_bit_cnt actual=%0d required=0", bit_cnt); else pass_cnt++;
    endtask

    task automatic test_lsb_first();
        send_word(1'b1, 6'b101100);
        total_cnt++; if (q !== 6'h0D) $display("FAIL lsb_q actual=%h required=%h", q, 6'h0D); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b1) $display("FAIL lsb_valid actual=%b required=1", data_valid); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 3'd0) $display("FAIL lsb_bit_cnt actual=%0d required=0", bit_cnt); else pass_cnt++;
        accept();
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL lsb_drain actual=%b required=0", data_valid); else pass_cnt++;
    endtask

    task automatic test_msb_first();
        send_word(1'b0, 6'b101100);
        total_cnt++; if (q !== 6'h2C) $display("FAIL msb_q actual=%h required=%h", q, 6'h2C); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b1) $display("FAIL msb_valid actual=%b required=1", data_valid); else pass_cnt++;
        tick();
        total_cnt++; if (data_valid !== 1'b1) $display("FAIL msb_hold_valid actual=%b required=1", data_valid); else pass_cnt++;
        accept();
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL msb_drain actual=%b required=0", data_valid); else pass_cnt++;
        total_cnt++; if (q !== 6'h2C) $display("FAIL msb_q_hold actual=%h required=%h", q, 6'h2C); else pass_cnt++;
    endtask

    task automatic test_mode_change();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        total_cnt++; if (q !== 6'h0D) $display("FAIL mode_latch_q actual=%h required=%h", q, 6'h0D); else pass_cnt++;
        accept();
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_word(1'b1, 6'b101100);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_pre actual=%b required=0", overrun); else pass_cnt++;
        send_word(1'b0, 6'b101100);
        total_cnt++; if (q !== 6'h0D) $display("FAIL ovr_q actual=%h required=%h", q, 6'h0D); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag actual=%b required=1", overrun); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b1) $display("FAIL ovr_valid actual=%b required=1", data_valid); else pass_cnt++;
        // word C, LSB-first bits 0,1,1,1,0,1 -> 6'b101110
        data_ready = 1'b1;
        send_word(1'b1, 6'b011101);
        data_ready = 1'b0;
        total_cnt++; if (q !== 6'h2E) $display("FAIL ovr_c_q actual=%h required=%h", q, 6'h2E); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b1) $display("FAIL ovr_c_valid actual=%b required=1", data_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky actual=%b required=1", overrun); else pass_cnt++;
        accept();
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky2 actual=%b required=1", overrun); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq;
        seq = 6'b101100;
        do_reset();
        send_word(1'b1, seq);
        for (int i = 5; i >= 1; i--) begin
            send_bit(1'b0, seq[i]);
        end
        data_ready = 1'b1;
        send_bit(1'b0, seq[0]);
        data_ready = 1'b0;
        total_cnt++; if (q !== 6'h2C) $display("FAIL b2b_q actual=%h required=%h", q, 6'h2C); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b1) $display("FAIL b2b_valid actual=%b required=1", data_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun actual=%b required=0", overrun); else pass_cnt++;
        accept();
    endtask

    task automatic test_sync();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        total_cnt++; if (bit_cnt !== 3'd3) $display("FAIL sync_pre_cnt actual=%0d required=3", bit_cnt); else pass_cnt++;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        total_cnt++; if (bit_cnt !== 3'd0) $display("FAIL sync_idle_cnt actual=%0d required=0", bit_cnt); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL sync_idle_valid actual=%b required=0", data_valid); else pass_cnt++;
        send_word(1'b0, 6'b101100);
        total_cnt++; if (q !== 6'h2C) $display("FAIL sync_clean_q actual=%h required=%h", q, 6'h2C); else pass_cnt++;
        accept();
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0, 1'b1);
        end
        sync = 1'b1;
        send_bit(1'b1, 1'b1);
        sync = 1'b0;
        total_cnt++; if (bit_cnt !== 3'd1) $display("FAIL sync_en_cnt actual=%0d required=1", bit_cnt); else pass_cnt++;
        // remaining bits of LSB-first 1,0,1,1,0,0 with mode input now 0
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        total_cnt++; if (q !== 6'h0D) $display("FAIL sync_en_q actual=%h required=%h", q, 6'h0D); else pass_cnt++;
        accept();
    endtask

    task automatic test_rst_mid();
        send_word(1'b0, 6'b101100);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        do_reset();
        total_cnt++; if (q !== 6'h00) $display("FAIL rst_mid_q actual=%h required=%h", q, 6'h00); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL rst_mid_valid actual=%b required=0", data_valid); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 3'd0) $display("FAIL rst_mid_cnt actual=%0d required=0", bit_cnt); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rst_mid_overrun actual=%b required=0", overrun); else pass_cnt++;
        send_word(1'b1, 6'b101100);
        total_cnt++; if (q !== 6'h0D) $display("FAIL rst_after_q actual=%h required=%h", q, 6'h0D); else pass_cnt++;
    endtask

    initial begin
        rst        = 1'b0;
        mode       = 1'b0;
        serial_in  = 1'b0;
        in_en      = 1'b0;
        sync       = 1'b0;
        data_ready = 1'b0;
        #1;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_mode_change();
        test_overrun();
        test_back_to_back();
        test_sync();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
